// File: rtl/viterbi_ctrl_if.sv
// Control and handshake bundle between the Viterbi sequencer and its environment
// (frame source, slicer, BM/ACS enables, traceback).
interface viterbi_ctrl_if;
    logic       i_start;
    logic       i_code_rate;
    logic       i_frame_valid;
    logic       o_frame_ready;
    logic       o_load;
    logic       o_code_rate;
    logic       i_ood;
    logic       i_tb_done;
    logic       o_en_s;
    logic       o_en_bm;
    logic       o_en_acs;
    logic       o_en_tb;
    logic [6:0] o_step_cnt;
    logic       o_busy;
    logic       o_done;
    logic       o_err;

    modport master (
        output i_start, i_code_rate, i_frame_valid, i_ood, i_tb_done,
        input  o_frame_ready, o_load, o_code_rate, o_en_s, o_en_bm, o_en_acs,
               o_en_tb, o_step_cnt, o_busy, o_done, o_err
    );

    modport slave (
        input  i_start, i_code_rate, i_frame_valid, i_ood, i_tb_done,
        output o_frame_ready, o_load, o_code_rate, o_en_s, o_en_bm, o_en_acs,
               o_en_tb, o_step_cnt, o_busy, o_done, o_err
    );
endinterface

// File: rtl/viterbi_ctrl.sv
// Viterbi decoder sequencer: frame handshake, staggered slicer/BM/ACS enables,
// pipeline drain, traceback supervision and done/error reporting.
module viterbi_ctrl #(
    parameter int STEPS_R2   = 69,
    parameter int STEPS_R3   = 46,
    parameter int PIPE_LAT   = 2,
    parameter int TB_TIMEOUT = 255
) (
    input logic           clk,
    input logic           rst,
    viterbi_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_TB    = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam int         DW     = (PIPE_LAT > 1) ? $clog2(PIPE_LAT + 1) : 1;
    localparam int         TW     = $clog2(TB_TIMEOUT + 1);
    localparam logic [6:0] LIM_R2 = 7'(STEPS_R2);
    localparam logic [6:0] LIM_R3 = 7'(STEPS_R3);

    logic [2:0]        state, state_nxt;
    logic              code_rate;
    logic [6:0]        s_cnt;
    logic [6:0]        step_cnt, step_nxt;
    logic [DW-1:0]     drain_cnt;
    logic [TW-1:0]     tb_cnt;
    logic              ood_seen;
    logic              err;
    logic [PIPE_LAT:1] vld_pipe;

    logic       en_s, en_acs;
    logic [6:0] limit;
    logic       run_end, drain_end, tb_timeout;

    assign en_s       = (state == S_RUN);
    assign en_acs     = vld_pipe[PIPE_LAT];
    assign limit      = code_rate ? LIM_R3 : LIM_R2;
    // Exit is decided in the cycle that issues the last slicer enable.
    assign run_end    = en_s && (bus.i_ood || (s_cnt == limit - 7'd1));
    assign drain_end  = (state == S_DRAIN) && (drain_cnt == DW'(PIPE_LAT - 1));
    assign tb_timeout = (tb_cnt == TW'(TB_TIMEOUT - 1));
    assign step_nxt   = (en_acs && (step_cnt != 7'h7f)) ? step_cnt + 7'd1 : step_cnt;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.i_start)       state_nxt = S_WAIT;
            S_WAIT:  if (bus.i_frame_valid) state_nxt = S_LOAD;
            S_LOAD:                         state_nxt = S_RUN;
            S_RUN:   if (run_end)           state_nxt = S_DRAIN;
            S_DRAIN: if (drain_end)         state_nxt = S_TB;
            S_TB:    if (bus.i_tb_done || tb_timeout) state_nxt = S_DONE;
            S_DONE:                         state_nxt = S_IDLE;
            default:                        state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            code_rate <= 1'b0;
            s_cnt     <= '0;
            step_cnt  <= '0;
            drain_cnt <= '0;
            tb_cnt    <= '0;
            ood_seen  <= 1'b0;
            err       <= 1'b0;
            vld_pipe  <= '0;
        end else begin
            state       <= state_nxt;
            step_cnt    <= step_nxt;
            vld_pipe[1] <= en_s;
            for (int k = 2; k <= PIPE_LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
            case (state)
                S_IDLE: if (bus.i_start) begin
                    code_rate <= bus.i_code_rate;
                    err       <= 1'b0;
                    step_cnt  <= '0;
                end
                S_LOAD: begin
                    s_cnt     <= '0;
                    drain_cnt <= '0;
                    tb_cnt    <= '0;
                    ood_seen  <= 1'b0;
                end
                S_RUN: begin
                    s_cnt <= s_cnt + 7'd1;
                    if (bus.i_ood) ood_seen <= 1'b1;
                end
                S_DRAIN: begin
                    drain_cnt <= drain_cnt + DW'(1);
                    // Without end-of-data, every issued slice must have produced an ACS step.
                    if (drain_end && !ood_seen && (step_nxt != limit)) err <= 1'b1;
                end
                S_TB: begin
                    tb_cnt <= tb_cnt + TW'(1);
                    if (tb_timeout && !bus.i_tb_done) err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_frame_ready = (state == S_WAIT);
    assign bus.o_load        = (state == S_LOAD);
    assign bus.o_code_rate   = code_rate;
    assign bus.o_en_s        = en_s;
    assign bus.o_en_bm       = vld_pipe[1];
    assign bus.o_en_acs      = en_acs;
    assign bus.o_en_tb       = (state == S_TB);
    assign bus.o_step_cnt    = step_cnt;
    assign bus.o_busy        = (state != S_IDLE);
    assign bus.o_done        = (state == S_DONE);
    assign bus.o_err         = err;
endmodule
